he_hssi_tg_sequencer: RTL and testbench
=======================================

// Module: he_hssi_tg_sequencer
// PURPOSE
//  Sequences the HE-HSSI traffic generator for one Ethernet port: on start, emits cfg_num_pkt
//  AXI-S TX packets of fixed or pseudo-random length with an incremental or PRBS payload.
//  Counts packets sent and active cycles so software computes throughput KPI.
//  Sits between the HE-HSSI CSR block (config/start/stop) and the MAC TX AXI-S input.
// PARAMETERS
//  DATA_W   64    TX data width in bits; DATA_W/8 bytes per beat, power of 2, 32..512
//  LEN_W    16    packet length field width (bytes)
//  MIN_LEN  64    minimum packet length, bytes
//  MAX_LEN  1518  maximum packet length, bytes
//  CNT_W    32    width of packet and cycle counters
// PORTS
//  clk               in   1         user clock (402.83 MHz)
//  rst_n             in   1         async active-low reset
//  cfg_num_pkt       in   CNT_W     packets per run
//  cfg_pkt_len       in   LEN_W     fixed length, bytes
//  cfg_len_random    in   1         1: pseudo-random length, 0: fixed
//  cfg_data_random   in   1         1: PRBS payload, 0: incremental
//  start             in   1         1-cycle pulse: begin run
//  stop              in   1         1-cycle pulse: end run after current packet
//  tx_tvalid         out  1         AXI-S valid
//  tx_tready         in   1         AXI-S ready
//  tx_tdata          out  DATA_W    AXI-S data, byte 0 in [7:0]
//  tx_tkeep          out  DATA_W/8  byte enables, LSB-contiguous
//  tx_tlast          out  1         last beat of packet
//  busy              out  1         run in progress
//  done              out  1         1-cycle pulse at end of run
//  pkt_sent_cnt      out  CNT_W     packets completed this run
//  active_cycles     out  CNT_W     cycles from first tvalid to final tlast handshake, inclusive
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; LFSRs seeded (len 16'hACE1, data 32'hFFFF_FFFF).
//  FSM: IDLE -start-> LOAD -> SEND -(last tlast hs | stop seen)-> DONE -> IDLE.
//   IDLE: start latches config, clears counters, reseeds LFSRs; busy=1 from next cycle.
//   LOAD (1 cycle): computes length of packet 0; if cfg_num_pkt==0 goes straight to DONE.
//   SEND: tx_tvalid=1 first cycle in SEND (start->tvalid latency 2 clk).
//   DONE: done=1 one cycle, busy=0 next cycle; counters hold until next start.
//  Handshake = tvalid&tready. Once tvalid=1, tvalid/tdata/tkeep/tlast hold until handshake.
//   Back-to-back packets, no idle beat between tlast and next first beat.
//  Length: fixed = clamp(cfg_pkt_len, MIN_LEN, MAX_LEN). Random = clamp(len_lfsr[10:0],
//   MIN_LEN, MAX_LEN); 16-bit LFSR x^16+x^14+x^13+x^11+1 steps once per packet, on tlast hs.
//  Beats/pkt = ceil(len/(DATA_W/8)); last beat tkeep = low (len mod (DATA_W/8)) bits set,
//   all ones if remainder 0; other beats all ones.
//  Payload: incremental -> byte k of packet = k[7:0], restarts at 0 each packet; PRBS ->
//   32-bit LFSR x^32+x^22+x^2+x+1 replicated across DATA_W, steps per beat handshake.
//   Bytes outside tkeep are 0.
//  pkt_sent_cnt +1 on each tlast handshake. active_cycles +1 every cycle from first tvalid to
//   final tlast hs, inclusive, stalls included. Both saturate at all ones.
//  stop: recorded in SEND; current packet completes, then DONE. stop in IDLE/DONE ignored.
//  start while busy ignored. start+stop same cycle in IDLE: run starts, stop ignored.
//  rst_n low mid-packet: tvalid drops at once (async), truncated packet not counted.
// TESTING
//  1 DATA_W=64, num_pkt=0x80, len=0x84, fixed/incr, tready=1 -> 17 beats/pkt, last tkeep=0x0F,
//    pkt_sent_cnt=0x80, active_cycles=2176, one done pulse.
//  2 As 1, tready toggling 1/0 each cycle -> data stable while stalled, active_cycles=4351,
//    byte sequence 0x00..0x83 per packet.
//  3 num_pkt=0 -> no tvalid, done 2 cycles after start, counters 0.
//  4 num_pkt=1000, stop pulsed mid-packet 5 -> packet 5 completes, pkt_sent_cnt=6.
//  5 len_random=1, 500 pkts -> every length in [64,1518], tkeep matches length.
//  6 rst_n low mid-packet 3 -> tvalid=0 same cycle; after release, start runs clean from pkt 0.

Source files
------------

// File: rtl/he_hssi_tg_sequencer_if.sv
// AXI-S TX bus between the traffic-generator sequencer and the MAC TX input.
interface he_hssi_tg_sequencer_if #(
    parameter int unsigned DATA_W = 64
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_W-1:0]     tdata;
    logic [DATA_W/8-1:0]   tkeep;
    logic                  tlast;

    modport master (output tvalid, tdata, tkeep, tlast, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/he_hssi_tg_sequencer.sv
// HE-HSSI traffic generator sequencer: emits a run of fixed/random-length AXI-S packets
// with incremental or PRBS payload and keeps packet / active-cycle counters for KPI.
module he_hssi_tg_sequencer #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned LEN_W   = 16,
    parameter int unsigned MIN_LEN = 64,
    parameter int unsigned MAX_LEN = 1518,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CNT_W-1:0]          cfg_num_pkt,
    input  logic [LEN_W-1:0]          cfg_pkt_len,
    input  logic                      cfg_len_random,
    input  logic                      cfg_data_random,
    input  logic                      start,
    input  logic                      stop,
    he_hssi_tg_sequencer_if.master    tx,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_W-1:0]          pkt_sent_cnt,
    output logic [CNT_W-1:0]          active_cycles
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam logic [15:0] LEN_SEED  = 16'hACE1;
    localparam logic [31:0] DATA_SEED = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   num_pkt_q;
    logic [LEN_W-1:0]   len_fixed_q;
    logic               len_random_q;
    logic               data_random_q;
    logic [15:0]        len_lfsr;
    logic [31:0]        data_lfsr;
    logic [LEN_W-1:0]   rem;
    logic [LEN_W-1:0]   pos;
    logic               stop_seen;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        if (l < LEN_W'(MIN_LEN)) return LEN_W'(MIN_LEN);
        if (l > LEN_W'(MAX_LEN)) return LEN_W'(MAX_LEN);
        return l;
    endfunction

    // x^16+x^14+x^13+x^11+1, Fibonacci, shifting left
    function automatic logic [15:0] len_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // x^32+x^22+x^2+x+1, Fibonacci, shifting left
    function automatic logic [31:0] data_step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    function automatic logic [BYTES-1:0] keep_of(input logic [LEN_W-1:0] r);
        logic [BYTES-1:0] k;
        for (int i = 0; i < BYTES; i++) k[i] = (LEN_W'(i) < r);
        return k;
    endfunction

    // Beat payload: byte i is the packet byte offset (pos+i) or the replicated PRBS word
    function automatic logic [DATA_W-1:0] beat_data(input logic [LEN_W-1:0] r,
                                                    input logic [LEN_W-1:0] p,
                                                    input logic [31:0]      lf,
                                                    input logic             rnd);
        logic [DATA_W-1:0] d;
        logic [BYTES-1:0]  k;
        k = keep_of(r);
        d = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (k[i]) d[8*i +: 8] = rnd ? lf[8*(i%4) +: 8] : 8'(p + LEN_W'(i));
        end
        return d;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

    logic               hs;
    logic [15:0]        len_lfsr_nxt;
    logic [31:0]        data_lfsr_nxt;
    logic [LEN_W-1:0]   first_len;
    logic [LEN_W-1:0]   next_len;
    logic [LEN_W-1:0]   beat_rem;
    logic [LEN_W-1:0]   beat_pos;
    logic               final_pkt;

    always_comb begin
        hs            = tx.tvalid & tx.tready;
        len_lfsr_nxt  = len_step(len_lfsr);
        data_lfsr_nxt = data_step(data_lfsr);
        first_len     = len_random_q ? clamp_len(LEN_W'(len_lfsr[10:0])) : len_fixed_q;
        next_len      = len_random_q ? clamp_len(LEN_W'(len_lfsr_nxt[10:0])) : len_fixed_q;
        beat_rem      = rem - LEN_W'(BYTES);
        beat_pos      = pos + LEN_W'(BYTES);
        final_pkt     = (pkt_sent_cnt + CNT_W'(1)) == num_pkt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            num_pkt_q     <= '0;
            len_fixed_q   <= '0;
            len_random_q  <= 1'b0;
            data_random_q <= 1'b0;
            len_lfsr      <= LEN_SEED;
            data_lfsr     <= DATA_SEED;
            rem           <= '0;
            pos           <= '0;
            stop_seen     <= 1'b0;
            tx.tvalid     <= 1'b0;
            tx.tdata      <= '0;
            tx.tkeep      <= '0;
            tx.tlast      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pkt_sent_cnt  <= '0;
            active_cycles <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        num_pkt_q     <= cfg_num_pkt;
                        len_fixed_q   <= clamp_len(cfg_pkt_len);
                        len_random_q  <= cfg_len_random;
                        data_random_q <= cfg_data_random;
                        len_lfsr      <= LEN_SEED;
                        data_lfsr     <= DATA_SEED;
                        stop_seen     <= 1'b0;
                        pkt_sent_cnt  <= '0;
                        active_cycles <= '0;
                        busy          <= 1'b1;
                        state         <= LOAD;
                    end
                end
                LOAD: begin
                    if (num_pkt_q == '0) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        rem       <= first_len;
                        pos       <= '0;
                        tx.tvalid <= 1'b1;
                        tx.tdata  <= beat_data(first_len, '0, data_lfsr, data_random_q);
                        tx.tkeep  <= keep_of(first_len);
                        tx.tlast  <= (first_len <= LEN_W'(BYTES));
                        state     <= SEND;
                    end
                end
                SEND: begin
                    active_cycles <= sat_inc(active_cycles);
                    if (stop) stop_seen <= 1'b1;
                    if (hs) begin
                        data_lfsr <= data_lfsr_nxt;
                        if (tx.tlast) begin
                            pkt_sent_cnt <= sat_inc(pkt_sent_cnt);
                            len_lfsr     <= len_lfsr_nxt;
                            if (final_pkt || stop_seen || stop) begin
                                tx.tvalid <= 1'b0;
                                tx.tdata  <= '0;
                                tx.tkeep  <= '0;
                                tx.tlast  <= 1'b0;
                                done      <= 1'b1;
                                state     <= DONE;
                            end else begin
                                // next packet follows with no idle beat
                                rem      <= next_len;
                                pos      <= '0;
                                tx.tdata <= beat_data(next_len, '0, data_lfsr_nxt, data_random_q);
                                tx.tkeep <= keep_of(next_len);
                                tx.tlast <= (next_len <= LEN_W'(BYTES));
                            end
                        end else begin
                            rem      <= beat_rem;
                            pos      <= beat_pos;
                            tx.tdata <= beat_data(beat_rem, beat_pos, data_lfsr_nxt, data_random_q);
                            tx.tkeep <= keep_of(beat_rem);
                            tx.tlast <= (beat_rem <= LEN_W'(BYTES));
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_he_hssi_tg_sequencer.sv
// Directed self-checking bench for he_hssi_tg_sequencer (DATA_W=64).
module tb_he_hssi_tg_sequencer;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned CNT_W  = 32;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [CNT_W-1:0]   cfg_num_pkt;
    logic [LEN_W-1:0]   cfg_pkt_len;
    logic               cfg_len_random;
    logic               cfg_data_random;
    logic               start;
    logic               stop;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   pkt_sent_cnt;
    logic [CNT_W-1:0]   active_cycles;

    he_hssi_tg_sequencer_if #(.DATA_W(DATA_W)) tx ();

    he_hssi_tg_sequencer #(
        .DATA_W(DATA_W), .LEN_W(LEN_W), .MIN_LEN(64), .MAX_LEN(1518), .CNT_W(CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_num_pkt     (cfg_num_pkt),
        .cfg_pkt_len     (cfg_pkt_len),
        .cfg_len_random  (cfg_len_random),
        .cfg_data_random (cfg_data_random),
        .start           (start),
        .stop            (stop),
        .tx              (tx),
        .busy            (busy),
        .done            (done),
        .pkt_sent_cnt    (pkt_sent_cnt),
        .active_cycles   (active_cycles)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int          r_beats, r_pkts, r_bad, r_done, r_min, r_max, r_len0, r_len1, r_active;
    logic [7:0]  r_lastkeep;
    logic [63:0] r_lastdata;
    logic [63:0] r_d [3];
    bit          r_timeout;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Start a run and observe the bus until busy falls after done; scoreboard beats inline.
    task automatic run_pkts(input int budget, input bit tgl, input int exp_len,
                            input int stop_pkt, input bit data_rand);
        int          k, n;
        bit          stall, stop_req, stopped, seen_done;
        logic [63:0] sd;
        logic [7:0]  skeep, b;
        logic        slast;
        r_beats = 0; r_pkts = 0; r_bad = 0; r_done = 0; r_active = 0;
        r_min = 100000; r_max = 0; r_len0 = -1; r_len1 = -1;
        r_lastkeep = '0; r_lastdata = '0;
        for (int i = 0; i < 3; i++) r_d[i] = '0;
        k = 0; stall = 0; stop_req = 0; stopped = 0; seen_done = 0;
        sd = '0; skeep = '0; slast = 1'b0;
        tx.tready = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        r_timeout = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (seen_done && !busy) begin
                r_timeout = 1'b0;
                break;
            end
            if (done) begin
                r_done++;
                seen_done = 1;
            end
            if (tx.tvalid) begin
                r_active++;
                if (stall && (tx.tdata !== sd || tx.tkeep !== skeep || tx.tlast !== slast)) r_bad++;
                if (tx.tready) begin
                    n = $countones(tx.tkeep);
                    if ((tx.tkeep & (tx.tkeep + 8'd1)) != 0 || n == 0 ||
                        (!tx.tlast && tx.tkeep != 8'hFF)) r_bad++;
                    for (int j = 0; j < 8; j++) begin
                        b = tx.tdata[8*j +: 8];
                        if (j >= n && b != 8'h00) r_bad++;
                        else if (j < n && !data_rand && b != 8'(k + j)) r_bad++;
                    end
                    if (data_rand && r_beats < 3) r_d[r_beats] = tx.tdata;
                    r_beats++;
                    k += n;
                    r_lastkeep = tx.tkeep;
                    r_lastdata = tx.tdata;
                    if (tx.tlast) begin
                        if (r_pkts == 0) r_len0 = k;
                        if (r_pkts == 1) r_len1 = k;
                        if (k < r_min) r_min = k;
                        if (k > r_max) r_max = k;
                        if (exp_len != 0 && k != exp_len) r_bad++;
                        r_pkts++;
                        k = 0;
                    end
                    stall = 0;
                end else begin
                    stall = 1;
                    sd = tx.tdata; skeep = tx.tkeep; slast = tx.tlast;
                end
                if (stop_pkt >= 0 && !stopped && r_pkts == stop_pkt && k >= 40) begin
                    stop_req = 1;
                    stopped  = 1;
                end
            end
            @(posedge clk); #1;
            stop = stop_req;
            stop_req = 0;
            tx.tready = tgl ? ((r_active % 2) == 0) : 1'b1;
        end
        stop = 1'b0;
        tx.tready = 1'b1;
    endtask

    int cnt3;

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; tx.tready = 1'b1;
        cfg_num_pkt = '0; cfg_pkt_len = '0; cfg_len_random = 1'b0; cfg_data_random = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_tvalid", tx.tvalid, 0);
        check("rst_tkeep", tx.tkeep, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pkt_cnt", pkt_sent_cnt, 0);
        check("rst_active", active_cycles, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // start -> tvalid latency and first beat of a single 64-byte packet
        cfg_num_pkt = 32'd1; cfg_pkt_len = 16'd64;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("lat_busy", busy, 1);
        check("lat_tvalid0", tx.tvalid, 0);
        @(negedge clk);
        check("lat_tvalid1", tx.tvalid, 1);
        check("lat_data0", tx.tdata, 64'h0706_0504_0302_0100);
        for (int c = 0; c < 50 && busy; c++) @(negedge clk);
        check("lat_busy_end", busy, 0);
        check("lat_pkt_cnt", pkt_sent_cnt, 1);
        check("lat_active", active_cycles, 8);

        // 128 x 132-byte packets, incremental, tready=1
        cfg_num_pkt = 32'h80; cfg_pkt_len = 16'h84;
        run_pkts(5000, 0, 132, -1, 0);
        check("t1_timeout", r_timeout, 0);
        check("t1_pkts", r_pkts, 128);
        check("t1_pkt_cnt", pkt_sent_cnt, 32'h80);
        check("t1_active", active_cycles, 2176);
        check("t1_beats", r_beats, 2176);
        check("t1_lastkeep", r_lastkeep, 8'h0F);
        check("t1_lastdata", r_lastdata, 64'h0000_0000_8382_8180);
        check("t1_done_pulses", r_done, 1);
        check("t1_bad_beats", r_bad, 0);

        // same with tready toggling every cycle
        run_pkts(10000, 1, 132, -1, 0);
        check("t2_timeout", r_timeout, 0);
        check("t2_pkts", r_pkts, 128);
        check("t2_active", active_cycles, 4351);
        check("t2_bad_beats", r_bad, 0);

        // zero packets
        cfg_num_pkt = 32'd0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("t3_done_early", done, 0);
        check("t3_busy", busy, 1);
        @(negedge clk);
        check("t3_done", done, 1);
        check("t3_tvalid", tx.tvalid, 0);
        @(negedge clk);
        check("t3_done_clr", done, 0);
        check("t3_busy_clr", busy, 0);
        check("t3_pkt_cnt", pkt_sent_cnt, 0);
        check("t3_active", active_cycles, 0);

        // stop during packet 5 of a 1000-packet run
        cfg_num_pkt = 32'd1000; cfg_pkt_len = 16'd132;
        run_pkts(3000, 0, 132, 5, 0);
        check("t4_timeout", r_timeout, 0);
        check("t4_pkts", r_pkts, 6);
        check("t4_pkt_cnt", pkt_sent_cnt, 6);
        check("t4_done_pulses", r_done, 1);
        check("t4_bad_beats", r_bad, 0);

        // length clamping
        cfg_num_pkt = 32'd1; cfg_pkt_len = 16'd10;
        run_pkts(200, 0, 64, -1, 0);
        check("clamp_lo_len", r_len0, 64);
        check("clamp_lo_keep", r_lastkeep, 8'hFF);
        cfg_pkt_len = 16'd2000;
        run_pkts(400, 0, 1518, -1, 0);
        check("clamp_hi_len", r_len0, 1518);
        check("clamp_hi_beats", r_beats, 190);
        check("clamp_hi_keep", r_lastkeep, 8'h3F);

        // PRBS payload
        cfg_pkt_len = 16'd64; cfg_data_random = 1'b1;
        run_pkts(200, 0, 64, -1, 1);
        check("prbs_beat0", r_d[0], 64'hFFFF_FFFF_FFFF_FFFF);
        check("prbs_beat1", r_d[1], 64'hFFFF_FFFE_FFFF_FFFE);
        check("prbs_beat2", r_d[2], 64'hFFFF_FFFD_FFFF_FFFD);
        check("prbs_bad_beats", r_bad, 0);
        cfg_data_random = 1'b0;

        // random lengths
        cfg_num_pkt = 32'd500; cfg_len_random = 1'b1;
        run_pkts(100000, 0, 0, -1, 0);
        check("t5_timeout", r_timeout, 0);
        check("t5_pkts", r_pkts, 500);
        check("t5_len0", r_len0, 1249);
        check("t5_len1", r_len1, 451);
        check("t5_min_ok", r_min >= 64, 1);
        check("t5_max_ok", r_max <= 1518, 1);
        check("t5_bad_beats", r_bad, 0);
        cfg_len_random = 1'b0;

        // async reset during packet 3
        cfg_num_pkt = 32'd10; cfg_pkt_len = 16'd132;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cnt3 = 0;
        for (int c = 0; c < 2000 && cnt3 < 4; c++) begin
            @(negedge clk);
            if (pkt_sent_cnt == 3) cnt3++;
        end
        check("t6_reached_pkt3", cnt3, 4);
        check("t6_tvalid_pre", tx.tvalid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_tvalid_rst", tx.tvalid, 0);
        check("t6_busy_rst", busy, 0);
        check("t6_pkt_cnt_rst", pkt_sent_cnt, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        cfg_num_pkt = 32'd2;
        run_pkts(200, 0, 132, -1, 0);
        check("t6_timeout", r_timeout, 0);
        check("t6_pkts", r_pkts, 2);
        check("t6_pkt_cnt", pkt_sent_cnt, 2);
        check("t6_active", active_cycles, 34);
        check("t6_bad_beats", r_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
